// File: rtl/bcrypt_key_storage_b.sv
// Double-buffered key byte store: streams a key into one bank, zero-terminates it,
// and presents completed keys to the expanded-key builder with an async byte read port.
module bcrypt_key_storage_b #(
    parameter int KEY_LEN = 72,
    localparam int AW = $clog2(KEY_LEN)
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_wr_en,
    input  logic          in_last,
    input  logic          in_sign_ext,
    output logic          in_full,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    dout,
    output logic          word_empty,
    input  logic          word_set_empty,
    output logic          sign_extension_bug
);

    localparam logic [1:0] W_DATA = 2'd0;
    localparam logic [1:0] W_TERM = 2'd1;
    localparam logic [1:0] W_SKIP = 2'd2;

    localparam logic [AW-1:0] LAST_DATA_PTR = AW'(KEY_LEN - 2);

    logic [7:0]    mem [2][KEY_LEN];

    logic [1:0]    state_reg, state_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic          skip_pending_reg, skip_pending_next;
    logic          flag_latch_reg, flag_latch_next;
    logic          wr_bank_reg, rd_bank_reg;
    logic [1:0]    full_reg;
    logic [1:0]    flag_reg;

    logic          accept;
    logic          release_bank;
    logic          commit;
    logic          commit_flag;
    logic          mem_we;
    logic [7:0]    mem_wdata;

    assign in_full = ((state_reg == W_DATA) && full_reg[wr_bank_reg]) || (state_reg == W_TERM);
    assign accept  = in_wr_en && !in_full;

    // Release is only honoured when the read bank really holds a key.
    assign release_bank       = word_set_empty && full_reg[rd_bank_reg];
    assign word_empty         = !full_reg[rd_bank_reg];
    assign sign_extension_bug = flag_reg[rd_bank_reg];

    always_comb begin
        state_next        = state_reg;
        wr_ptr_next       = wr_ptr_reg;
        skip_pending_next = skip_pending_reg;
        flag_latch_next   = flag_latch_reg;
        mem_we            = 1'b0;
        mem_wdata         = in_data;
        commit            = 1'b0;
        commit_flag       = flag_latch_reg;
        case (state_reg)
            W_DATA: begin
                if (accept) begin
                    mem_we = 1'b1;
                    if (wr_ptr_reg == '0) begin
                        flag_latch_next = in_sign_ext;
                    end
                    if (in_data == 8'h00) begin
                        // A zero byte is its own terminator: commit without a W_TERM cycle.
                        commit      = 1'b1;
                        commit_flag = (wr_ptr_reg == '0) ? in_sign_ext : flag_latch_reg;
                        state_next  = in_last ? W_DATA : W_SKIP;
                    end else begin
                        wr_ptr_next = wr_ptr_reg + 1'b1;
                        if (in_last) begin
                            state_next        = W_TERM;
                            skip_pending_next = 1'b0;
                        end else if (wr_ptr_reg == LAST_DATA_PTR) begin
                            state_next        = W_TERM;
                            skip_pending_next = 1'b1;
                        end
                    end
                end
            end
            W_TERM: begin
                mem_we     = 1'b1;
                mem_wdata  = 8'h00;
                commit     = 1'b1;
                state_next = skip_pending_reg ? W_SKIP : W_DATA;
            end
            W_SKIP: begin
                if (accept && in_last) begin
                    state_next = W_DATA;
                end
            end
            default: begin
                state_next = W_DATA;
            end
        endcase
        if (commit) begin
            wr_ptr_next = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_reg        <= W_DATA;
            wr_ptr_reg       <= '0;
            skip_pending_reg <= 1'b0;
            flag_latch_reg   <= 1'b0;
            wr_bank_reg      <= 1'b0;
            rd_bank_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            wr_ptr_reg       <= wr_ptr_next;
            skip_pending_reg <= skip_pending_next;
            flag_latch_reg   <= flag_latch_next;
            wr_bank_reg      <= wr_bank_reg ^ commit;
            rd_bank_reg      <= rd_bank_reg ^ release_bank;
        end
    end

    // Commit and release always target different banks, so per-bank priority is safe.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            always_ff @(posedge CLK) begin
                if (rst) begin
                    full_reg[gi] <= 1'b0;
                    flag_reg[gi] <= 1'b0;
                end else if (commit && (wr_bank_reg == 1'(gi))) begin
                    full_reg[gi] <= 1'b1;
                    flag_reg[gi] <= commit_flag;
                end else if (release_bank && (rd_bank_reg == 1'(gi))) begin
                    full_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[wr_bank_reg][wr_ptr_reg] <= mem_wdata;
        end
    end

    assign dout = (int'(rd_addr) < KEY_LEN) ? mem[rd_bank_reg][rd_addr] : 8'h00;

endmodule

// File: tb/tb_bcrypt_key_storage_b.sv
// Bench for bcrypt_key_storage_b: directed scenarios plus a random byte stream,
// checked against a queue-of-keys model of the double buffer.
module tb_bcrypt_key_storage_b;

    localparam int KEY_LEN = 72;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_wr_en = 1'b0;
    logic       in_last = 1'b0;
    logic       in_sign_ext = 1'b0;
    logic       in_full;
    logic [6:0] rd_addr = 7'd0;
    logic [7:0] dout;
    logic       word_empty;
    logic       word_set_empty = 1'b0;
    logic       sign_extension_bug;

    int errors = 0;
    int checks = 0;

    // Model: committed keys in presentation order (bytes incl. terminator), plus key under construction.
    logic [7:0] kb[$];
    int         kl[$];
    logic       kf[$];
    logic [7:0] cur[$];
    logic       cur_flag = 1'b0;
    logic       skipping = 1'b0;
    logic       term_pending = 1'b0;
    logic       skip_after = 1'b0;

    bcrypt_key_storage_b #(.KEY_LEN(KEY_LEN)) dut (
        .CLK(CLK),
        .rst(rst),
        .in_data(in_data),
        .in_wr_en(in_wr_en),
        .in_last(in_last),
        .in_sign_ext(in_sign_ext),
        .in_full(in_full),
        .rd_addr(rd_addr),
        .dout(dout),
        .word_empty(word_empty),
        .word_set_empty(word_set_empty),
        .sign_extension_bug(sign_extension_bug)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_commit();
        foreach (cur[i]) kb.push_back(cur[i]);
        kb.push_back(8'h00);
        kl.push_back(cur.size() + 1);
        kf.push_back(cur_flag);
        cur.delete();
    endtask

    task automatic model_clear();
        kb.delete(); kl.delete(); kf.delete(); cur.delete();
        skipping = 1'b0; term_pending = 1'b0; skip_after = 1'b0;
    endtask

    task automatic check_read();
        chk("word_empty", word_empty, kl.size() == 0);
        if (kl.size() > 0) begin
            int a;
            chk("sign_ext", sign_extension_bug, kf[0]);
            a = $urandom_range(kl[0] - 1, 0);
            rd_addr = 7'(a);
            #1;
            chk("dout_rand", dout, kb[a]);
        end
    endtask

    // One clock cycle: check in_full, drive inputs, advance model and DUT, check read side.
    task automatic step(input logic we, input logic [7:0] d, input logic l, input logic se,
                        input logic rel, output logic acc);
        logic exp_full;
        exp_full = term_pending || (!skipping && kl.size() == 2);
        in_wr_en = we; in_data = d; in_last = l; in_sign_ext = se; word_set_empty = rel;
        chk("in_full", in_full, exp_full);
        acc = we && !exp_full;
        if (rel && kl.size() > 0) begin
            for (int i = 0; i < kl[0]; i++) void'(kb.pop_front());
            void'(kl.pop_front());
            void'(kf.pop_front());
        end
        if (term_pending) begin
            model_commit();
            term_pending = 1'b0;
            skipping = skip_after;
        end else if (acc) begin
            if (skipping) begin
                if (l) skipping = 1'b0;
            end else begin
                if (cur.size() == 0) cur_flag = se;
                if (d == 8'h00) begin
                    model_commit();
                    skipping = !l;
                end else begin
                    cur.push_back(d);
                    if (l) begin
                        term_pending = 1'b1; skip_after = 1'b0;
                    end else if (cur.size() == KEY_LEN - 1) begin
                        term_pending = 1'b1; skip_after = 1'b1;
                    end
                end
            end
        end
        @(posedge CLK);
        #1;
        in_wr_en = 1'b0; word_set_empty = 1'b0; in_last = 1'b0;
        check_read();
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
    endtask

    task automatic send_key(input logic [7:0] bytes[$], input logic se);
        logic acc;
        foreach (bytes[i]) begin
            int guard;
            guard = 0;
            acc = 1'b0;
            while (!acc) begin
                step(1'b1, bytes[i], i == bytes.size() - 1, se, 1'b0, acc);
                guard++;
                if (!acc && guard > 200) begin
                    errors++;
                    $error("FAIL send_timeout observed=stalled expected=accepted");
                    return;
                end
            end
        end
    endtask

    task automatic dump_front(input string tag);
        if (kl.size() == 0) return;
        for (int a = 0; a < kl[0]; a++) begin
            rd_addr = 7'(a);
            #1;
            chk(tag, dout, kb[a]);
        end
    endtask

    task automatic drain();
        logic acc;
        int guard;
        guard = 0;
        while ((kl.size() > 0 || term_pending) && guard < 10) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
            guard++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge CLK);
        #1;
        rst = 1'b0;
        model_clear();
        chk("rst_word_empty", word_empty, 1'b1);
        chk("rst_in_full", in_full, 1'b0);
        chk("rst_sign_ext", sign_extension_bug, 1'b0);
    endtask

    initial begin
        logic [7:0] key[$];
        logic acc;
        logic [7:0] sd[$];
        logic       sl[$];
        logic       ss[$];
        int cyc;

        @(posedge CLK);
        #1;
        do_reset();

        // Short key with flag: one stall cycle for the terminator.
        key = '{8'h61, 8'h62, 8'h63};
        send_key(key, 1'b1);
        idle(1);
        chk("t1_front_len", kl.size() > 0 ? kl[0] : 0, 4);
        dump_front("t1_dout");
        drain();

        // Over-long key: truncated to KEY_LEN-1 bytes, remainder discarded.
        key.delete();
        for (int i = 0; i < 100; i++) key.push_back(8'h41);
        send_key(key, 1'b0);
        key = '{8'h42, 8'h43};
        send_key(key, 1'b1);
        idle(2);
        dump_front("t2_long_dout");
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
        dump_front("t2_next_dout");
        drain();

        // Embedded zero terminates the key early.
        key = '{8'h61, 8'h00, 8'h62, 8'h63};
        send_key(key, 1'b0);
        idle(1);
        dump_front("t3_dout");
        drain();

        // Both banks full, then release one.
        key = '{8'h11, 8'h12}; send_key(key, 1'b0);
        key = '{8'h21, 8'h22}; send_key(key, 1'b1);
        idle(1);
        step(1'b1, 8'h31, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 8'h31, 1'b0, 1'b0, 1'b1, acc);
        key = '{8'h31, 8'h32}; send_key(key, 1'b0);
        idle(1);
        dump_front("t4_dout");
        drain();

        // Commit of key B on the same edge as release of key A.
        key = '{8'h71, 8'h72}; send_key(key, 1'b0);
        idle(1);
        key = '{8'h51, 8'h52}; send_key(key, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
        dump_front("t5_dout");
        drain();

        // Reset in the middle of a key.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b1, 1'b0, acc);
        do_reset();
        key = '{8'h91, 8'h92, 8'h93};
        send_key(key, 1'b0);
        idle(1);
        dump_front("t6_dout");
        drain();

        // Random stream of keys with random gaps and releases.
        for (int k = 0; k < 50; k++) begin
            int len;
            logic f;
            len = $urandom_range(100, 1);
            f = 1'($urandom_range(1, 0));
            for (int i = 0; i < len; i++) begin
                sd.push_back(($urandom_range(19, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 1)));
                sl.push_back(i == len - 1);
                ss.push_back(f);
            end
        end
        cyc = 0;
        while (sd.size() > 0 && cyc < 20000) begin
            logic we;
            logic rel;
            we  = ($urandom_range(9, 0) < 8);
            rel = ($urandom_range(9, 0) < 3);
            step(we, sd[0], sl[0], ss[0], rel, acc);
            if (acc) begin
                void'(sd.pop_front()); void'(sl.pop_front()); void'(ss.pop_front());
            end
            cyc++;
        end
        if (sd.size() > 0) begin
            errors++;
            $error("FAIL random_timeout observed=%0d expected=0 bytes left", sd.size());
        end
        idle(1);
        dump_front("rand_dout");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
